risc16_seq_ctrl: RTL

Multi-cycle control sequencer for the 16-bit RiSC datapath (8 x 16-bit register file, ALU, PC, shared memory port). It fetches one instruction per pass and decodes opcode [15:13]. It then drives the per-state control strobes that were previously generated combinationally in a single-cycle loop: ALU op and source, register write, memory access and PC update. It sits between the datapath and a single request/acknowledge memory port shared by fetch and load/store.

---
 rtl/risc16_seq_if.sv | 31 +++
 rtl/risc16_seq_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/risc16_seq_if.sv
// Sequencer-side bundle: shared memory request/ack port plus datapath control strobes.
// master = risc16_seq_ctrl, slave = datapath/memory side.
interface risc16_seq_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel;
  logic        mem_ack;
  logic [15:0] instr;
  logic        alu_eq;
  logic        ir_load;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic        rf_we;
  logic [1:0]  rf_wsel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        halt;
  logic        fault;

  modport master (
    input  mem_ack, instr, alu_eq,
    output mem_req, mem_we, mem_sel, ir_load, alu_op, alu_src,
           rf_we, rf_wsel, pc_we, pc_sel, halt, fault
  );

  modport slave (
    output mem_ack, instr, alu_eq,
    input  mem_req, mem_we, mem_sel, ir_load, alu_op, alu_src,
           rf_we, rf_wsel, pc_we, pc_sel, halt, fault
  );
endinterface

// File: rtl/risc16_seq_ctrl.sv
// Multi-cycle RiSC-16 control sequencer (fetch/decode/exec/mem/wb) on a shared req/ack memory port.
// Optional memory-ack timeout enabled by defining RISC16_SEQ_MEMTIMEOUT_EN.
module risc16_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  risc16_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  state_e      r_state;
  state_e      w_nxt;
  logic [15:0] r_ir;
  logic [2:0]  w_op;
  logic        w_ra_zero;
  logic        w_is_halt;
  logic        w_to_hit;

  logic       r_mem_req, r_mem_we, r_mem_sel, r_alu_src, r_rf_we, r_pc_we, r_halt, r_fault;
  logic [1:0] r_alu_op, r_rf_wsel, r_pc_sel;
  logic       w_nx_mem_req, w_nx_mem_we, w_nx_mem_sel, w_nx_alu_src;
  logic       w_nx_rf_we, w_nx_pc_we, w_nx_halt, w_nx_fault;
  logic [1:0] w_nx_alu_op, w_nx_rf_wsel, w_nx_pc_sel;

  assign w_op      = r_ir[15:13];
  assign w_ra_zero = (r_ir[12:10] == 3'd0);
  assign w_is_halt = (w_op == OP_JALR) && (r_ir[12:7] == 6'd0) && (r_ir[6:0] != 7'd0);

`ifdef RISC16_SEQ_MEMTIMEOUT_EN
  // Wait counter for the current memory request; an ack on the limit cycle still wins.
  logic [TO_W-1:0] r_to_cnt;
  logic            w_waiting;

  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ack;
  assign w_to_hit  = w_waiting && (r_to_cnt == TO_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_waiting && !w_to_hit) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end
`else
  logic w_unused_to;
  assign w_unused_to = (MEM_TIMEOUT >= (32'd1 << TO_W));
  assign w_to_hit    = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   w_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ack)   w_nxt = S_DECODE;
        else if (w_to_hit) w_nxt = S_FAULT;
      end
      S_DECODE: w_nxt = S_EXEC;
      S_EXEC: begin
        case (w_op)
          OP_BEQ:       w_nxt = S_FETCH;
          OP_JALR:      w_nxt = w_is_halt ? S_HALT : S_FETCH;
          OP_SW, OP_LW: w_nxt = S_MEM;
          default:      w_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ack)   w_nxt = (w_op == OP_SW) ? S_FETCH : S_WB;
        else if (w_to_hit) w_nxt = S_FAULT;
      end
      S_WB:     w_nxt = S_FETCH;
      default:  w_nxt = r_state;
    endcase
  end

  // Moore strobes decoded for the state being entered, so they are registered.
  always_comb begin
    w_nx_mem_req = 1'b0;
    w_nx_mem_we  = 1'b0;
    w_nx_mem_sel = 1'b0;
    w_nx_alu_op  = 2'b00;
    w_nx_alu_src = 1'b0;
    w_nx_rf_we   = 1'b0;
    w_nx_rf_wsel = 2'b00;
    w_nx_pc_we   = 1'b0;
    w_nx_pc_sel  = 2'b00;
    w_nx_halt    = 1'b0;
    w_nx_fault   = 1'b0;
    case (w_nxt)
      S_FETCH: w_nx_mem_req = 1'b1;
      S_EXEC: begin
        case (w_op)
          OP_ADD:                w_nx_alu_src = 1'b0;
          OP_ADDI, OP_SW, OP_LW: w_nx_alu_src = 1'b1;
          OP_NAND:               w_nx_alu_op  = 2'b01;
          OP_LUI:                w_nx_alu_op  = 2'b10;
          OP_BEQ: begin
            w_nx_alu_op = 2'b11;
            w_nx_pc_we  = 1'b1;
          end
          OP_JALR: begin
            if (!w_is_halt) begin
              w_nx_rf_we   = !w_ra_zero;
              w_nx_rf_wsel = 2'b10;
              w_nx_pc_we   = 1'b1;
              w_nx_pc_sel  = 2'b10;
            end
          end
          default: w_nx_alu_src = 1'b0;
        endcase
      end
      S_MEM: begin
        w_nx_mem_req = 1'b1;
        w_nx_mem_sel = 1'b1;
        w_nx_mem_we  = (w_op == OP_SW);
      end
      S_WB: begin
        w_nx_rf_we   = !w_ra_zero;
        w_nx_rf_wsel = (w_op == OP_LW) ? 2'b01 : 2'b00;
        w_nx_pc_we   = 1'b1;
      end
      S_HALT:  w_nx_halt  = 1'b1;
      S_FAULT: w_nx_fault = 1'b1;
      default: w_nx_halt  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_sel <= 1'b0;
      r_alu_op  <= 2'b00;
      r_alu_src <= 1'b0;
      r_rf_we   <= 1'b0;
      r_rf_wsel <= 2'b00;
      r_pc_we   <= 1'b0;
      r_pc_sel  <= 2'b00;
      r_halt    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if ((r_state == S_FETCH) && bus.mem_ack) r_ir <= bus.instr;
      r_mem_req <= w_nx_mem_req;
      r_mem_we  <= w_nx_mem_we;
      r_mem_sel <= w_nx_mem_sel;
      r_alu_op  <= w_nx_alu_op;
      r_alu_src <= w_nx_alu_src;
      r_rf_we   <= w_nx_rf_we;
      r_rf_wsel <= w_nx_rf_wsel;
      r_pc_we   <= w_nx_pc_we;
      r_pc_sel  <= w_nx_pc_sel;
      r_halt    <= w_nx_halt;
      r_fault   <= w_nx_fault;
    end
  end

  // Ack- and compare-qualified strobes must react within the current cycle.
  assign bus.ir_load = (r_state == S_FETCH) && bus.mem_ack;
  assign bus.pc_we   = r_pc_we || ((r_state == S_MEM) && (w_op == OP_SW) && bus.mem_ack);
  assign bus.pc_sel  = ((r_state == S_EXEC) && (w_op == OP_BEQ)) ? {1'b0, bus.alu_eq} : r_pc_sel;

  assign bus.mem_req = r_mem_req;
  assign bus.mem_we  = r_mem_we;
  assign bus.mem_sel = r_mem_sel;
  assign bus.alu_op  = r_alu_op;
  assign bus.alu_src = r_alu_src;
  assign bus.rf_we   = r_rf_we;
  assign bus.rf_wsel = r_rf_wsel;
  assign bus.halt    = r_halt;
  assign bus.fault   = r_fault;

endmodule
